// File: rtl/uart_prog_loader_pkg.sv
// Shared constants and state encoding for the UART program loader.
package uart_prog_loader_pkg;

  localparam logic [7:0]  SYNC_BYTE = 8'hAA;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned BYTE_W    = 8;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    WAIT_TX,
    LEN,
    DATA,
    DONE,
    ERR
  } loader_state_t;

endpackage

// File: rtl/uart_prog_loader_word_assembler.sv
// Big-endian 4-byte word assembler.
// Ports:
//   clk, rstn        clock, async active-low reset
//   byte_in          incoming byte
//   byte_valid       byte_in is valid this cycle
//   clear            drop any partial word
//   word_out_c       assembled word (valid with word_valid_c)
//   word_valid_c     high in the cycle the 4th byte arrives
module uart_prog_loader_word_assembler
  import uart_prog_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic [BYTE_W-1:0] byte_in,
  input  logic              byte_valid,
  input  logic              clear,
  output logic [WORD_W-1:0] word_out_c,
  output logic              word_valid_c
);

  logic [WORD_W-BYTE_W-1:0] r_shift;
  logic [1:0]               r_cnt;

  // Keep the first three bytes; the 4th is merged combinationally so the
  // owner can register the complete word on the same edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_shift <= '0;
      r_cnt   <= 2'd0;
    end else if (clear) begin
      r_cnt   <= 2'd0;
    end else if (byte_valid) begin
      r_shift <= {r_shift[WORD_W-2*BYTE_W-1:0], byte_in};
      r_cnt   <= r_cnt + 2'd1;
    end
  end

  assign word_valid_c = byte_valid && !clear && (r_cnt == 2'd3);
  assign word_out_c   = {r_shift, byte_in};

endmodule

// File: rtl/uart_prog_loader.sv
// Program loader: sends the sync byte, receives a word count and that many
// big-endian words over UART, and writes them to IMEM from address 0.
// Ports:
//   clk, rstn            clock, async active-low reset
//   load_en              LOAD mode level
//   rx_data/rx_ready     received byte and its strobe
//   rx_ferr              framing error, qualified by rx_ready
//   tx_busy              uart_tx busy
//   tx_start/tx_data     sync byte request to uart_tx
//   imem_we/addr/wdata   IMEM write port
//   busy/done/err        loader status
module uart_prog_loader
  import uart_prog_loader_pkg::*;
#(
  parameter int unsigned IMEM_ADDR_W = 14
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   load_en,
  input  logic [BYTE_W-1:0]      rx_data,
  input  logic                   rx_ready,
  input  logic                   rx_ferr,
  input  logic                   tx_busy,
  output logic                   tx_start,
  output logic [BYTE_W-1:0]      tx_data,
  output logic                   imem_we,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0]      imem_wdata,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int unsigned      CNT_W     = IMEM_ADDR_W + 1;
  localparam logic [WORD_W-1:0] MAX_WORDS = WORD_W'(1) << IMEM_ADDR_W;

  loader_state_t           r_state;
  logic                    r_first;
  logic [CNT_W-1:0]        r_len;
  logic [CNT_W-1:0]        r_wcnt;
  logic                    r_last;
  logic                    r_tx_start;
  logic [BYTE_W-1:0]       r_tx_data;
  logic                    r_imem_we;
  logic [IMEM_ADDR_W-1:0]  r_imem_addr;
  logic [WORD_W-1:0]       r_imem_wdata;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_err;

  logic                    w_active;
  logic                    w_byte_valid;
  logic                    w_ferr;
  logic [WORD_W-1:0]       w_word;
  logic                    w_word_valid;
  logic [CNT_W-1:0]        w_wcnt_next;

  // Bytes only count in LEN/DATA; a framed-bad byte never enters the word.
  assign w_active     = (r_state == LEN) || (r_state == DATA);
  assign w_byte_valid = rx_ready && !rx_ferr && w_active;
  assign w_ferr       = rx_ready && rx_ferr && w_active;
  assign w_wcnt_next  = r_wcnt + CNT_W'(1);

  uart_prog_loader_word_assembler u_asm (
    .clk          (clk),
    .rstn         (rstn),
    .byte_in      (rx_data),
    .byte_valid   (w_byte_valid),
    .clear        (!w_active),
    .word_out_c   (w_word),
    .word_valid_c (w_word_valid)
  );

  // Loader FSM with registered outputs; load_en low aborts any busy state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= IDLE;
      r_first      <= 1'b0;
      r_len        <= '0;
      r_wcnt       <= '0;
      r_last       <= 1'b0;
      r_tx_start   <= 1'b0;
      r_tx_data    <= '0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_tx_start <= 1'b0;
      r_imem_we  <= 1'b0;
      if (!load_en && r_busy) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: if (load_en) begin
            r_state    <= SYNC;
            r_tx_start <= 1'b1;
            r_tx_data  <= SYNC_BYTE;
            r_busy     <= 1'b1;
          end
          SYNC: begin
            r_state <= WAIT_TX;
            r_first <= 1'b1;
          end
          // First cycle is skipped so tx_busy has time to rise.
          WAIT_TX: begin
            if (r_first)       r_first <= 1'b0;
            else if (!tx_busy) r_state <= LEN;
          end
          LEN: begin
            if (w_ferr) begin
              r_state <= ERR;
              r_err   <= 1'b1;
              r_busy  <= 1'b0;
            end else if (w_word_valid) begin
              if (w_word == '0) begin
                r_state <= DONE;
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
              end else if (w_word > MAX_WORDS) begin
                r_state <= ERR;
                r_err   <= 1'b1;
                r_busy  <= 1'b0;
              end else begin
                r_state <= DATA;
                r_len   <= CNT_W'(w_word);
                r_wcnt  <= '0;
                r_last  <= 1'b0;
              end
            end
          end
          // r_last delays done by one cycle so it follows the final write.
          DATA: begin
            if (r_last) begin
              r_state <= DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else if (w_ferr) begin
              r_state <= ERR;
              r_err   <= 1'b1;
              r_busy  <= 1'b0;
            end else if (w_word_valid) begin
              r_imem_we    <= 1'b1;
              r_imem_addr  <= r_wcnt[IMEM_ADDR_W-1:0];
              r_imem_wdata <= w_word;
              r_wcnt       <= w_wcnt_next;
              r_last       <= (w_wcnt_next == r_len);
            end
          end
          DONE: if (!load_en) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
          end
          ERR: if (!load_en) begin
            r_state <= IDLE;
            r_err   <= 1'b0;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign tx_start   = r_tx_start;
  assign tx_data    = r_tx_data;
  assign imem_we    = r_imem_we;
  assign imem_addr  = r_imem_addr;
  assign imem_wdata = r_imem_wdata;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Testbench for uart_prog_loader: expected IMEM writes and sync bytes are
// queued by the stimulus and popped by a monitor when the DUT strobes them.
module tb_uart_prog_loader;

  localparam int unsigned AW = 14;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          load_en = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_ready = 1'b0;
  logic          rx_ferr = 1'b0;
  logic          tx_busy = 1'b0;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          busy;
  logic          done;
  logic          err;

  int n_vec = 0;
  int n_err = 0;
  int busy_len = 3;
  int tx_cnt = 0;

  logic [45:0] exp_wr[$];
  logic [7:0]  exp_tx[$];

  uart_prog_loader #(.IMEM_ADDR_W(AW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .load_en    (load_en),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .rx_ferr    (rx_ferr),
    .tx_busy    (tx_busy),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations on each DUT strobe; also models uart_tx busy.
  always @(negedge clk) begin
    if (tx_start) begin
      if (exp_tx.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_tx_start: got tx_data %h, required no strobe", tx_data);
      end else begin
        check("tx_data", 32'(tx_data), 32'(exp_tx.pop_front()));
      end
      tx_cnt = busy_len;
    end
    tx_busy = (tx_cnt > 0);
    if (tx_cnt > 0) tx_cnt--;
    if (imem_we) begin
      if (exp_wr.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: got addr %0d data %h, required no write", imem_addr, imem_wdata);
      end else begin
        logic [45:0] e;
        e = exp_wr.pop_front();
        check("write_addr", 32'(imem_addr), 32'(e[45:32]));
        check("write_data", imem_wdata, e[31:0]);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic fe);
    rx_data  = b;
    rx_ready = 1'b1;
    rx_ferr  = fe;
    @(negedge clk);
    rx_ready = 1'b0;
    rx_ferr  = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], 1'b0);
  endtask

  task automatic start_load();
    exp_tx.push_back(8'hAA);
    load_en = 1'b1;
    repeat (busy_len + 6) @(negedge clk);
    check("sync_sent", 32'(exp_tx.size()), 32'd0);
    check("busy_in_len", 32'(busy), 32'd1);
  endtask

  task automatic end_load();
    load_en = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);
    check("idle_err", 32'(err), 32'd0);
    check("writes_drained", 32'(exp_wr.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_imem_we", 32'(imem_we), 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    check("rst_imem_wdata", imem_wdata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Sync handshake with a long tx_busy; bytes during WAIT_TX are dropped.
    busy_len = 10;
    exp_tx.push_back(8'hAA);
    load_en = 1'b1;
    repeat (4) @(negedge clk);
    send_word(32'h0000_0000);
    check("drop_in_wait_tx", 32'(done), 32'd0);
    repeat (6) @(negedge clk);
    check("one_sync", 32'(exp_tx.size()), 32'd0);
    check("busy_after_tx", 32'(busy), 32'd1);
    send_word(32'h0000_0000);
    check("len0_done", 32'(done), 32'd1);
    end_load();
    busy_len = 3;

    // Two back-to-back words.
    start_load();
    exp_wr.push_back({14'd0, 32'hDEAD_BEEF});
    exp_wr.push_back({14'd1, 32'h0123_4567});
    send_word(32'h0000_0002);
    send_word(32'hDEAD_BEEF);
    send_word(32'h0123_4567);
    check("last_we", 32'(imem_we), 32'd1);
    check("done_not_yet", 32'(done), 32'd0);
    @(negedge clk);
    check("done_after_write", 32'(done), 32'd1);
    check("busy_in_done", 32'(busy), 32'd0);
    end_load();

    // Zero length.
    start_load();
    send_word(32'h0000_0000);
    check("zero_done", 32'(done), 32'd1);
    check("zero_no_we", 32'(imem_we), 32'd0);
    end_load();

    // Length one past capacity.
    start_load();
    send_word(32'h0000_4001);
    check("over_err", 32'(err), 32'd1);
    check("over_busy", 32'(busy), 32'd0);
    end_load();

    // Exactly capacity is accepted; abort it.
    start_load();
    send_word(32'h0000_4000);
    check("cap_no_err", 32'(err), 32'd0);
    check("cap_busy", 32'(busy), 32'd1);
    end_load();

    // Framing error on the 3rd byte of a data word.
    start_load();
    send_word(32'h0000_0001);
    send_byte(8'hDE, 1'b0);
    send_byte(8'hAD, 1'b0);
    send_byte(8'hBE, 1'b1);
    check("ferr_err", 32'(err), 32'd1);
    send_byte(8'hEF, 1'b0);
    @(negedge clk);
    check("ferr_hold", 32'(err), 32'd1);
    end_load();

    // Abort after 6 data bytes, then restart from a clean word boundary.
    start_load();
    exp_wr.push_back({14'd0, 32'h1122_3344});
    send_word(32'h0000_0002);
    send_word(32'h1122_3344);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    load_en = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_one_write", 32'(exp_wr.size()), 32'd0);
    start_load();
    exp_wr.push_back({14'd0, 32'hA1B2_C3D4});
    send_word(32'h0000_0001);
    send_word(32'hA1B2_C3D4);
    @(negedge clk);
    check("restart_done", 32'(done), 32'd1);
    end_load();

    // Reset asserted while a write strobe is active.
    start_load();
    send_word(32'h0000_0001);
    send_byte(8'hCA, 1'b0);
    send_byte(8'hFE, 1'b0);
    send_byte(8'hF0, 1'b0);
    rx_data  = 8'h0D;
    rx_ready = 1'b1;
    @(posedge clk);
    #2;
    rx_ready = 1'b0;
    check("we_before_rst", 32'(imem_we), 32'd1);
    rstn = 1'b0;
    #1;
    check("rst_async_we", 32'(imem_we), 32'd0);
    check("rst_async_addr", 32'(imem_addr), 32'd0);
    check("rst_async_wdata", imem_wdata, 32'd0);
    check("rst_async_busy", 32'(busy), 32'd0);
    check("rst_async_tx", 32'(tx_data), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    start_load();
    end_load();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
